exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
Exception/interrupt sequencer between the 5-stage pipeline and the CP0 register file, operating at the M stage.
- Selects the macroscopic PC and branch-delay flag, and forwards the M-stage exception code to CP0.
- On CP0 Req, issues pipeline flush and redirect to the handler; on eret, redirects to EPC.
- Synchronises the external HWInt lines.
- Holds eret in D while an mtc0 to EPC is in flight.

Parameters:
HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC
HWINT_W, 6, number of hardware interrupt lines

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; all state cleared on the rising clk edge where reset=1
hwint_in  in  HWINT_W  raw device interrupt lines (timer0, timer1, external)
m_valid  in  1  M stage holds a real instruction (0 = bubble)
m_pc  in  32  M-stage PC
m_bd  in  1  M-stage instruction is in a delay slot
m_exc  in  5  exception code carried to M (0 = none)
m_eret  in  1  eret in M
e_pc  in  32  E-stage PC; used when M is a bubble
e_bd  in  1  E-stage delay-slot flag
d_eret  in  1  eret in D
e_mtc0_epc  in  1  mtc0 with rd=14 in E
m_mtc0_epc  in  1  mtc0 with rd=14 in M
cp0_req  in  1  Req from CP0
cp0_epc  in  32  EPCout from CP0
cp0_vpc  out  32  macroscopic PC to CP0
cp0_isdb  out  1  delay-slot flag to CP0
cp0_exccode  out  5  exception code to CP0
cp0_exclr  out  1  eret clear of SR.EXL
cp0_hwint  out  HWINT_W  interrupt lines to CP0
flush  out  1  clear F/D/E/M pipeline registers
redirect  out  1  load redirect_pc into PC next edge
redirect_pc  out  32  target PC
stall_d  out  1  freeze F/D, bubble into E

Behaviour:
FSM states: RUN, TRAP, ERET.
- RUN -> TRAP when cp0_req=1 and state=RUN.
- RUN -> ERET when m_eret=1 and cp0_req=0.
- TRAP -> RUN and ERET -> RUN unconditionally after one cycle.
- cp0_req has priority over m_eret in the same cycle.

Macroscopic PC selection:
- m_valid=1: cp0_vpc=m_pc, cp0_isdb=m_bd.
- m_valid=0: cp0_vpc=e_pc, cp0_isdb=e_bd.
- Interrupts are never lost on bubbles.

Exception code:
- cp0_exccode = m_exc when state=RUN and m_valid=1; otherwise 0.
- This blocks double-take in TRAP/ERET and on flushed slots.

Redirect and flush:
- flush and redirect are combinational in the cycle the condition holds.
- cp0_req in RUN: flush=1, redirect=1, redirect_pc=HANDLER_ADDR.
- m_eret (taken path): flush=1, redirect=1, redirect_pc=cp0_epc, cp0_exclr=1 — same cycle, single-cycle pulse.
- In TRAP/ERET: flush=1 (squash wrong-path fetch already in F), redirect=0, cp0_exclr=0.

Eret/EPC hazard:
- stall_d = d_eret & (e_mtc0_epc | m_mtc0_epc).
- Gives 0-2 stall cycles.
- Forced 0 in TRAP/ERET.

Reset values:
- state=RUN.
- All outputs 0, except cp0_vpc/cp0_isdb, which follow their combinational selection.
- Synchroniser flops = 0.

Reset mid-TRAP/ERET: returns to RUN next cycle with no redirect.

Optional Feature:
EXC_CTRL_INT_SYNC_EN
- Defined: hwint_in passes through a 2-flop synchroniser; cp0_hwint lags hwint_in by 2 cycles.
- Undefined: cp0_hwint = hwint_in combinationally, 0 latency.

Decomposition:
Shared package:
- ExcCode constants: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
- HANDLER_ADDR default.
- CP0 register indices SR=12, Cause=13, EPC=14.
- FSM state encoding.

Sub-module: int_sync, a parameterised 2-flop synchroniser instantiated only under EXC_CTRL_INT_SYNC_EN.

Test Plan:
1. Overflow exception:
   - Stimulus: m_valid=1, m_pc=0x3010, m_exc=12, cp0_req=1.
   - Required: cp0_exccode=12, cp0_vpc=0x3010, flush=1, redirect_pc=0x4180 that cycle; next cycle state=TRAP, exccode=0, redirect=0, flush=1.
2. Interrupt on bubble:
   - Stimulus: m_valid=0, e_pc=0x3020, e_bd=1, cp0_req=1.
   - Required: cp0_vpc=0x3020, cp0_isdb=1, redirect_pc=0x4180.
3. Eret:
   - Stimulus: m_eret=1, cp0_epc=0x3040, cp0_req=0.
   - Required: cp0_exclr=1, redirect_pc=0x3040, flush=1 for one cycle; next cycle exclr=0.
4. Eret hazard:
   - Stimulus: d_eret=1 with e_mtc0_epc=1.
   - Required: stall_d=1 for 2 cycles, 0 once the mtc0 leaves M.
5. Simultaneous events:
   - Stimulus: cp0_req=1 and m_eret=1.
   - Required: handler redirect to 0x4180, cp0_exclr=0.
6. Synchroniser latency (EXC_CTRL_INT_SYNC_EN defined):
   - Stimulus: hwint_in=6'b000100.
   - Required: cp0_hwint=6'b000100 exactly 2 edges later.
   - Also: reset asserted during TRAP gives state=RUN and all outputs 0 next cycle.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/interrupt sequencer: exception codes,
// CP0 register indices, handler entry address and FSM state encoding.
package exc_ctrl_pkg;

   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;

   localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      TRAP = 2'd1,
      ERET = 2'd2
   } exc_state_t;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Parameterised two-flop synchroniser for asynchronous interrupt lines.
module exc_ctrl_int_sync #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= async_in;
         sync_p1 <= sync_p0;
      end
   end

   assign sync_out = sync_p1;

endmodule

// File: rtl/exc_ctrl.sv
// M-stage exception/interrupt sequencer between the pipeline and CP0.
// Define EXC_CTRL_INT_SYNC_EN to pass hwint_in through a 2-flop synchroniser.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
   parameter int          HWINT_W      = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [HWINT_W-1:0] hwint_in,
   input  logic               m_valid,
   input  logic [31:0]        m_pc,
   input  logic               m_bd,
   input  logic [4:0]         m_exc,
   input  logic               m_eret,
   input  logic [31:0]        e_pc,
   input  logic               e_bd,
   input  logic               d_eret,
   input  logic               e_mtc0_epc,
   input  logic               m_mtc0_epc,
   input  logic               cp0_req,
   input  logic [31:0]        cp0_epc,
   output logic [31:0]        cp0_vpc,
   output logic               cp0_isdb,
   output logic [4:0]         cp0_exccode,
   output logic               cp0_exclr,
   output logic [HWINT_W-1:0] cp0_hwint,
   output logic               flush,
   output logic               redirect,
   output logic [31:0]        redirect_pc,
   output logic               stall_d
);

   exc_state_t state;
   logic       in_run;
   logic       take_trap;
   logic       take_eret;

   assign in_run    = (state == RUN) && !reset;
   assign take_trap = in_run && cp0_req;
   assign take_eret = in_run && m_eret && !cp0_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (cp0_req)
                  state <= TRAP;
               else if (m_eret)
                  state <= ERET;
            end
            default: state <= RUN;
         endcase
      end
   end

   // A bubble in M reports the E-stage PC so an interrupt taken there is not lost.
   assign cp0_vpc  = m_valid ? m_pc : e_pc;
   assign cp0_isdb = m_valid ? m_bd : e_bd;

   assign cp0_exccode = (in_run && m_valid) ? m_exc : 5'd0;
   assign cp0_exclr   = take_eret;
   assign redirect    = take_trap || take_eret;
   // The cycle after a redirect still flushes the wrong-path fetch sitting in F.
   assign flush       = take_trap || take_eret || (!reset && state != RUN);
   assign stall_d     = in_run && d_eret && (e_mtc0_epc || m_mtc0_epc);

   always_comb begin
      redirect_pc = 32'd0;
      if (take_trap)
         redirect_pc = HANDLER_ADDR;
      else if (take_eret)
         redirect_pc = cp0_epc;
   end

`ifdef EXC_CTRL_INT_SYNC_EN
   exc_ctrl_int_sync #(
      .WIDTH(HWINT_W)
   ) u_int_sync (
      .clk     (clk),
      .reset   (reset),
      .async_in(hwint_in),
      .sync_out(cp0_hwint)
   );
`else
   assign cp0_hwint = hwint_in;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed scoreboard bench for exc_ctrl.
module tb_exc_ctrl;

   localparam int HW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic [HW-1:0] hwint_in;
   logic          m_valid;
   logic [31:0]   m_pc;
   logic          m_bd;
   logic [4:0]    m_exc;
   logic          m_eret;
   logic [31:0]   e_pc;
   logic          e_bd;
   logic          d_eret;
   logic          e_mtc0_epc;
   logic          m_mtc0_epc;
   logic          cp0_req;
   logic [31:0]   cp0_epc;
   logic [31:0]   cp0_vpc;
   logic          cp0_isdb;
   logic [4:0]    cp0_exccode;
   logic          cp0_exclr;
   logic [HW-1:0] cp0_hwint;
   logic          flush;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          stall_d;

   typedef struct packed {
      logic [31:0]   vpc;
      logic          isdb;
      logic [4:0]    exc;
      logic          exclr;
      logic          flush;
      logic          redir;
      logic [31:0]   rpc;
      logic          stall;
      logic [HW-1:0] hw;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks   = 0;
   int    failures = 0;

   exc_ctrl #(.HANDLER_ADDR(32'h0000_4180), .HWINT_W(HW)) dut (
      .clk        (clk),
      .reset      (reset),
      .hwint_in   (hwint_in),
      .m_valid    (m_valid),
      .m_pc       (m_pc),
      .m_bd       (m_bd),
      .m_exc      (m_exc),
      .m_eret     (m_eret),
      .e_pc       (e_pc),
      .e_bd       (e_bd),
      .d_eret     (d_eret),
      .e_mtc0_epc (e_mtc0_epc),
      .m_mtc0_epc (m_mtc0_epc),
      .cp0_req    (cp0_req),
      .cp0_epc    (cp0_epc),
      .cp0_vpc    (cp0_vpc),
      .cp0_isdb   (cp0_isdb),
      .cp0_exccode(cp0_exccode),
      .cp0_exclr  (cp0_exclr),
      .cp0_hwint  (cp0_hwint),
      .flush      (flush),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .stall_d    (stall_d)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
      end
   endtask

   task automatic idle();
      reset = 1'b0; hwint_in = '0; m_valid = 1'b0; m_pc = 32'd0; m_bd = 1'b0;
      m_exc = 5'd0; m_eret = 1'b0; e_pc = 32'd0; e_bd = 1'b0; d_eret = 1'b0;
      e_mtc0_epc = 1'b0; m_mtc0_epc = 1'b0; cp0_req = 1'b0; cp0_epc = 32'd0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Push the expectation for the inputs just driven, then compare at the falling edge.
   task automatic chk(input string tag, input logic [31:0] vpc, input logic isdb,
                      input logic [4:0] exc, input logic exclr, input logic fl,
                      input logic rd, input logic [31:0] rpc, input logic st,
                      input logic [HW-1:0] hw);
      exp_t e;
      string t;
      e = '{vpc: vpc, isdb: isdb, exc: exc, exclr: exclr, flush: fl, redir: rd,
            rpc: rpc, stall: st, hw: hw};
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "vpc",     cp0_vpc,             e.vpc);
      cmp(t, "isdb",    32'(cp0_isdb),       32'(e.isdb));
      cmp(t, "exccode", 32'(cp0_exccode),    32'(e.exc));
      cmp(t, "exclr",   32'(cp0_exclr),      32'(e.exclr));
      cmp(t, "flush",   32'(flush),          32'(e.flush));
      cmp(t, "redirect",32'(redirect),       32'(e.redir));
      cmp(t, "rpc",     redirect_pc,         e.rpc);
      cmp(t, "stall_d", 32'(stall_d),        32'(e.stall));
      cmp(t, "hwint",   32'(cp0_hwint),      32'(e.hw));
   endtask

   initial begin
      idle();
      reset = 1'b1;
      nxt();
      nxt();
      reset = 1'b0;
      chk("reset_idle", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, '0);

      // Overflow in M with CP0 request
      nxt(); m_valid = 1; m_pc = 32'h3010; m_exc = 5'd12; cp0_req = 1;
      chk("ov_take", 32'h3010, 0, 5'd12, 0, 1, 1, 32'h4180, 0, '0);
      nxt(); cp0_req = 0;
      chk("ov_trap", 32'h3010, 0, 5'd0, 0, 1, 0, 32'h0, 0, '0);
      nxt(); idle();
      chk("ov_back_run", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, '0);

      // Interrupt while M holds a bubble
      nxt(); e_pc = 32'h3020; e_bd = 1; cp0_req = 1; m_pc = 32'h9999; m_exc = 5'd4;
      chk("int_bubble", 32'h3020, 1, 5'd0, 0, 1, 1, 32'h4180, 0, '0);
      nxt(); idle();
      chk("int_trap", 32'h0, 0, 5'd0, 0, 1, 0, 32'h0, 0, '0);

      // Exception code forwarded in RUN without a request
      nxt(); m_valid = 1; m_pc = 32'h3024; m_bd = 1; m_exc = 5'd8;
      chk("syscall_fwd", 32'h3024, 1, 5'd8, 0, 0, 0, 32'h0, 0, '0);

      // Eret, then ERET state ignores held eret and forces stall_d low
      nxt(); idle(); m_valid = 1; m_pc = 32'h3030; m_eret = 1; cp0_epc = 32'h3040;
      chk("eret_take", 32'h3030, 0, 5'd0, 1, 1, 1, 32'h3040, 0, '0);
      nxt(); d_eret = 1; e_mtc0_epc = 1; m_exc = 5'd10;
      chk("eret_state", 32'h3030, 0, 5'd0, 0, 1, 0, 32'h0, 0, '0);

      // Eret/EPC hazard: mtc0 in E, then in M, then gone
      nxt(); idle(); d_eret = 1; e_mtc0_epc = 1;
      chk("haz_e", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 1, '0);
      nxt(); e_mtc0_epc = 0; m_mtc0_epc = 1;
      chk("haz_m", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 1, '0);
      nxt(); m_mtc0_epc = 0;
      chk("haz_clear", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, '0);
      nxt(); d_eret = 0; e_mtc0_epc = 1;
      chk("haz_no_eret", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, '0);

      // Request and eret together: request wins
      nxt(); idle(); cp0_req = 1; m_eret = 1; cp0_epc = 32'h3040;
      chk("both_take", 32'h0, 0, 5'd0, 0, 1, 1, 32'h4180, 0, '0);
      nxt(); idle();
      chk("both_trap", 32'h0, 0, 5'd0, 0, 1, 0, 32'h0, 0, '0);
      nxt();
      chk("both_run", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, '0);

      // Reset while in TRAP
      nxt(); cp0_req = 1;
      chk("rst_take", 32'h0, 0, 5'd0, 0, 1, 1, 32'h4180, 0, '0);
      nxt(); idle(); reset = 1;
      chk("rst_during_trap", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, '0);
      nxt(); reset = 0;
      chk("rst_after", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, '0);
      nxt(); m_eret = 1; cp0_epc = 32'h3050;
      chk("rst_run_eret", 32'h0, 0, 5'd0, 1, 1, 1, 32'h3050, 0, '0);
      nxt(); idle();
      chk("rst_eret_state", 32'h0, 0, 5'd0, 0, 1, 0, 32'h0, 0, '0);

      // Interrupt line latency
      nxt(); hwint_in = 6'b000100;
`ifdef EXC_CTRL_INT_SYNC_EN
      chk("hw_edge0", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, 6'b000000);
      nxt();
      chk("hw_edge1", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, 6'b000000);
      nxt();
      chk("hw_edge2", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, 6'b000100);
      nxt(); hwint_in = 6'b100001;
      chk("hw_hold", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, 6'b000100);
`else
      chk("hw_comb", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, 6'b000100);
      nxt(); hwint_in = 6'b100001;
      chk("hw_comb2", 32'h0, 0, 5'd0, 0, 0, 0, 32'h0, 0, 6'b100001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
